ref_fetch_sched: RTL and testbench

//   Sequences reference-window loading for the motion-estimation path, one macroblock (MB) at a time.

---
 rtl/ref_sched_pkg.sv | 24 ++
 rtl/ref_addr_gen.sv | 63 ++++++
 rtl/ref_fetch_sched.sv | 160 ++++++++++++++++
 tb/tb_ref_fetch_sched.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ref_sched_pkg.sv
// Shared state encoding, geometry constants and a counter-width helper
// for the reference-window fetch scheduler.
package ref_sched_pkg;

    localparam int unsigned STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t IDLE       = 3'd0;
    localparam state_t FETCH      = 3'd1;
    localparam state_t WAIT_READY = 3'd2;
    localparam state_t RUN        = 3'd3;
    localparam state_t ADVANCE    = 3'd4;
    localparam state_t DONE       = 3'd5;

    localparam int unsigned MB_SIZE    = 16;
    localparam int unsigned BEAT_BYTES = 8;
    localparam int unsigned SEARCH_EXT = 7;

    // Counter width that never collapses to zero bits for single-entry ranges
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ref_addr_gen.sv
// Search-window walker: row/beat counters and the external byte address
// of each 64-bit beat, registered as it is issued.
module ref_addr_gen
    import ref_sched_pkg::*;
#(
    parameter int unsigned ADDR_W        = 16,
    parameter int unsigned LINE_BYTES    = 48,
    parameter int unsigned WIN_ROWS      = 23,
    parameter int unsigned BEATS_PER_ROW = 3,
    parameter int unsigned MBX_W         = 1,
    parameter int unsigned MBY_W         = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              adv,
    input  logic [ADDR_W-1:0] base,
    input  logic [MBX_W-1:0]  mb_x,
    input  logic [MBY_W-1:0]  mb_y,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              last_beat
);

    localparam int unsigned ROW_W  = cnt_w(WIN_ROWS);
    localparam int unsigned BEAT_W = cnt_w(BEATS_PER_ROW);

    logic [ROW_W-1:0]  row;
    logic [BEAT_W-1:0] beat;
    logic [ADDR_W-1:0] line_idx;
    logic [ADDR_W-1:0] addr_c;
    logic              row_end;

    // Beat address; all terms are truncated to ADDR_W so the sum wraps
    always_comb begin
        row_end   = (beat == BEAT_W'(BEATS_PER_ROW - 1));
        last_beat = row_end && (row == ROW_W'(WIN_ROWS - 1));
        line_idx  = ADDR_W'(MB_SIZE) * ADDR_W'(mb_y) + ADDR_W'(row);
        addr_c    = base
                  + line_idx * ADDR_W'(LINE_BYTES)
                  + ADDR_W'(MB_SIZE) * ADDR_W'(mb_x)
                  + ADDR_W'(BEAT_BYTES) * ADDR_W'(beat);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row      <= '0;
            beat     <= '0;
            mem_addr <= '0;
        end else if (clr) begin
            row  <= '0;
            beat <= '0;
        end else if (adv) begin
            mem_addr <= addr_c;
            if (row_end) begin
                beat <= '0;
                row  <= row + 1'b1;
            end else begin
                beat <= beat + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ref_fetch_sched.sv
// Per-MB reference-window fetch sequencer for motion estimation.
// Define REF_STALL_CNT_EN to add the stall_cnt cycle counter output.
module ref_fetch_sched
    import ref_sched_pkg::*;
#(
    parameter int unsigned FRAME_W_MB    = 2,
    parameter int unsigned FRAME_H_MB    = 2,
    parameter int unsigned LINE_BYTES    = 48,
    parameter int unsigned WIN_ROWS      = MB_SIZE + SEARCH_EXT,
    parameter int unsigned BEATS_PER_ROW = 3,
    parameter int unsigned ADDR_W        = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [ADDR_W-1:0]               frame_base,
    input  logic                            ref_read_en,
    output logic                            mem_rd_en,
    output logic [ADDR_W-1:0]               mem_addr,
    input  logic                            sram_ready,
    output logic                            me_start,
    input  logic                            next_block,
    output logic [cnt_w(FRAME_W_MB)-1:0]    mb_x,
    output logic [cnt_w(FRAME_H_MB)-1:0]    mb_y,
    output logic                            busy,
    output logic                            frame_done,
    output logic                            err
`ifdef REF_STALL_CNT_EN
    ,
    output logic [31:0]                     stall_cnt
`endif
);

    localparam int unsigned MBX_W = cnt_w(FRAME_W_MB);
    localparam int unsigned MBY_W = cnt_w(FRAME_H_MB);

    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic              start_ok;
    logic              adv_addr;
    logic              clr_addr;
    logic              last_beat;
    logic              mb_x_last;
    logic              mb_last;

    always_comb begin
        start_ok  = (state == IDLE) && start;
        adv_addr  = (state == FETCH) && ref_read_en;
        clr_addr  = start_ok || (state == ADVANCE);
        mb_x_last = (mb_x == MBX_W'(FRAME_W_MB - 1));
        mb_last   = mb_x_last && (mb_y == MBY_W'(FRAME_H_MB - 1));
    end

    ref_addr_gen #(
        .ADDR_W        (ADDR_W),
        .LINE_BYTES    (LINE_BYTES),
        .WIN_ROWS      (WIN_ROWS),
        .BEATS_PER_ROW (BEATS_PER_ROW),
        .MBX_W         (MBX_W),
        .MBY_W         (MBY_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr_addr),
        .adv       (adv_addr),
        .base      (base_q),
        .mb_x      (mb_x),
        .mb_y      (mb_y),
        .mem_addr  (mem_addr),
        .last_beat (last_beat)
    );

    // Sequencer; protocol errors only raise err and never redirect the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            base_q     <= '0;
            mem_rd_en  <= 1'b0;
            me_start   <= 1'b0;
            mb_x       <= '0;
            mb_y       <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            mem_rd_en  <= adv_addr;
            me_start   <= 1'b0;
            frame_done <= 1'b0;
            if ((next_block && (state != RUN)) || (sram_ready && (state == FETCH))) begin
                err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q <= frame_base;
                        mb_x   <= '0;
                        mb_y   <= '0;
                        err    <= next_block;
                        busy   <= 1'b1;
                        state  <= FETCH;
                    end
                end
                FETCH: begin
                    if (ref_read_en && last_beat) begin
                        state <= WAIT_READY;
                    end
                end
                WAIT_READY: begin
                    if (sram_ready) begin
                        me_start <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (next_block) begin
                        state <= ADVANCE;
                    end
                end
                ADVANCE: begin
                    if (mb_last) begin
                        mb_x       <= '0;
                        mb_y       <= '0;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= DONE;
                    end else begin
                        if (mb_x_last) begin
                            mb_x <= '0;
                            mb_y <= mb_y + 1'b1;
                        end else begin
                            mb_x <= mb_x + 1'b1;
                        end
                        state <= FETCH;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef REF_STALL_CNT_EN
    // Saturating count of cycles lost waiting on RefSRAM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (start_ok) begin
            stall_cnt <= '0;
        end else if (((state == WAIT_READY) || ((state == FETCH) && !ref_read_en))
                     && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ref_fetch_sched.sv
// Randomized self-checking bench for ref_fetch_sched against an address/handshake model.
module tb_ref_fetch_sched;

    localparam int unsigned FW    = 2;
    localparam int unsigned FH    = 2;
    localparam int unsigned LB    = 48;
    localparam int unsigned BPR   = 3;
    localparam int unsigned BEATS = 23 * BPR;

    logic        clk         = 1'b0;
    logic        rst_n       = 1'b0;
    logic        start       = 1'b0;
    logic [15:0] frame_base  = 16'h0;
    logic        ref_read_en = 1'b0;
    logic        sram_ready  = 1'b0;
    logic        next_block  = 1'b0;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic        me_start;
    logic [0:0]  mb_x;
    logic [0:0]  mb_y;
    logic        busy;
    logic        frame_done;
    logic        err;
`ifdef REF_STALL_CNT_EN
    logic [31:0] stall_cnt;
    int unsigned stall_exp;
`endif

    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] cur_base    = 16'h0;

    always #5 clk = ~clk;

    ref_fetch_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .frame_base  (frame_base),
        .ref_read_en (ref_read_en),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .sram_ready  (sram_ready),
        .me_start    (me_start),
        .next_block  (next_block),
        .mb_x        (mb_x),
        .mb_y        (mb_y),
        .busy        (busy),
        .frame_done  (frame_done),
        .err         (err)
`ifdef REF_STALL_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    // k-th beat of MB (mx,my): window row k/BPR, beat k%BPR, padded-frame geometry
    function automatic logic [15:0] exp_addr(input logic [15:0] base, input int unsigned mx,
                                             input int unsigned my, input int unsigned k);
        int unsigned full;
        full = 32'(base) + (16 * my + k / BPR) * LB + 16 * mx + 8 * (k % BPR);
        return full[15:0];
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] base, input logic nb);
        frame_base = base;
        start      = 1'b1;
        next_block = nb;
        step;
        start      = 1'b0;
        next_block = 1'b0;
        cur_base   = base;
`ifdef REF_STALL_CNT_EN
        stall_exp  = 0;
`endif
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL start_busy: got %b expected 1", busy);
        end
        vectors++;
        if (err !== nb) begin
            miscompares++;
            $display("FAIL start_err: got %b expected %b", err, nb);
        end
        vectors++;
        if (mb_x !== 1'b0 || mb_y !== 1'b0) begin
            miscompares++;
            $display("FAIL start_mb: got (%0d,%0d) expected (0,0)", mb_x, mb_y);
        end
    endtask

    // Walk n_beats of a window, optionally injecting next_block / start / sram_ready at a beat index
    task automatic fetch_window(input int unsigned mx, input int unsigned my, input bit hold,
                                input int nb_at, input int st_at, input int rdy_at, input int n_beats);
        int k   = 0;
        int cyc = 0;
        bit nb_done = 0, st_done = 0, rdy_done = 0;
        ref_read_en = hold ? 1'b1 : ($urandom_range(0, 3) != 0);
`ifdef REF_STALL_CNT_EN
        if (!ref_read_en) stall_exp++;
`endif
        while (k < n_beats && cyc < 2000) begin
            step;
            cyc++;
            next_block = 1'b0;
            start      = 1'b0;
            sram_ready = 1'b0;
            if (mem_rd_en) begin
                vectors++;
                if (mem_addr !== exp_addr(cur_base, mx, my, k)) begin
                    miscompares++;
                    $display("FAIL fetch_addr mb(%0d,%0d) beat %0d: got %h expected %h",
                             mx, my, k, mem_addr, exp_addr(cur_base, mx, my, k));
                end
                k++;
            end
            if (k < n_beats) begin
                ref_read_en = hold ? 1'b1 : ($urandom_range(0, 3) != 0);
`ifdef REF_STALL_CNT_EN
                if (!ref_read_en) stall_exp++;
`endif
                if (k == nb_at && !nb_done) begin
                    next_block = 1'b1;
                    nb_done    = 1;
                end
                if (k == st_at && !st_done) begin
                    start      = 1'b1;
                    frame_base = ~cur_base;
                    st_done    = 1;
                end
                if (k == rdy_at && !rdy_done) begin
                    sram_ready = 1'b1;
                    rdy_done   = 1;
                end
            end
        end
        vectors++;
        if (k != n_beats) begin
            miscompares++;
            $display("FAIL fetch_count mb(%0d,%0d): got %0d beats expected %0d", mx, my, k, n_beats);
        end
    endtask

    // n cycles in WAIT_READY, the last with sram_ready high
    task automatic ready_handshake(input int n);
        for (int i = 0; i < n - 1; i++) begin
            step;
            vectors++;
            if (me_start !== 1'b0 || mem_rd_en !== 1'b0) begin
                miscompares++;
                $display("FAIL wait_idle: got me_start=%b mem_rd_en=%b expected 0 0", me_start, mem_rd_en);
            end
        end
        sram_ready = 1'b1;
        step;
        vectors++;
        if (me_start !== 1'b1) begin
            miscompares++;
            $display("FAIL me_start_pulse: got %b expected 1", me_start);
        end
        for (int i = 0; i < 2; i++) begin
            step;
            vectors++;
            if (me_start !== 1'b0 || mem_rd_en !== 1'b0) begin
                miscompares++;
                $display("FAIL me_start_repeat: got me_start=%b mem_rd_en=%b expected 0 0", me_start, mem_rd_en);
            end
        end
        sram_ready = 1'b0;
`ifdef REF_STALL_CNT_EN
        stall_exp += n;
        vectors++;
        if (stall_cnt !== stall_exp) begin
            miscompares++;
            $display("FAIL stall_cnt: got %0d expected %0d", stall_cnt, stall_exp);
        end
`endif
    endtask

    task automatic advance(input logic ex, input logic ey, input bit last, input logic exp_err);
        next_block = 1'b1;
        step;
        next_block = 1'b0;
        step;
        if (last) begin
            vectors++;
            if (frame_done !== 1'b1 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL frame_done: got done=%b busy=%b expected 1 0", frame_done, busy);
            end
            vectors++;
            if (mb_x !== 1'b0 || mb_y !== 1'b0 || err !== exp_err) begin
                miscompares++;
                $display("FAIL frame_end_state: got mb(%0d,%0d) err=%b expected (0,0) err=%b",
                         mb_x, mb_y, err, exp_err);
            end
            step;
            vectors++;
            if (frame_done !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL frame_done_len: got done=%b busy=%b expected 0 0", frame_done, busy);
            end
        end else begin
            vectors++;
            if (mb_x !== ex || mb_y !== ey || busy !== 1'b1 || frame_done !== 1'b0) begin
                miscompares++;
                $display("FAIL mb_step: got mb(%0d,%0d) busy=%b done=%b expected (%0d,%0d) 1 0",
                         mb_x, mb_y, busy, frame_done, ex, ey);
            end
        end
    endtask

    task automatic run_frame(input logic [15:0] base, input bit start_nb, input bit inj_nb, input bit inj_st);
        logic exp_err;
        exp_err = start_nb | inj_nb;
        do_start(base, start_nb);
        for (int m = 0; m < 4; m++) begin
            fetch_window(m % FW, m / FW, 0,
                         (inj_nb && m == 0) ? 10 : -1,
                         (inj_st && m == 0) ? 20 : -1,
                         (inj_nb && m == 0) ? 40 : -1, BEATS);
            vectors++;
            if (err !== exp_err) begin
                miscompares++;
                $display("FAIL err_flag mb %0d: got %b expected %b", m, err, exp_err);
            end
            ready_handshake($urandom_range(1, 6));
            advance(1'((m + 1) % FW), 1'(((m + 1) / FW) % FH), m == 3, exp_err);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (mem_rd_en !== 1'b0 || mem_addr !== 16'h0 || me_start !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_fetch: got rd=%b addr=%h me=%b expected 0 0000 0", mem_rd_en, mem_addr, me_start);
        end
        vectors++;
        if (busy !== 1'b0 || frame_done !== 1'b0 || err !== 1'b0 || mb_x !== 1'b0 || mb_y !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_status: got busy=%b done=%b err=%b mb(%0d,%0d) expected all 0",
                     busy, frame_done, err, mb_x, mb_y);
        end
        rst_n = 1'b1;
        step;
    endtask

    task automatic test_fetch_order;
        do_start(16'h0100, 1'b0);
        fetch_window(0, 0, 1, -1, -1, -1, BEATS);
    endtask

    task automatic test_ready_handshake;
        ready_handshake(5);
    endtask

    task automatic test_mb_stepping;
        advance(1'b1, 1'b0, 0, 1'b0);
        fetch_window(1, 0, 0, -1, -1, -1, BEATS);
        ready_handshake($urandom_range(1, 6));
        advance(1'b0, 1'b1, 0, 1'b0);
        fetch_window(0, 1, 0, -1, -1, -1, BEATS);
        ready_handshake($urandom_range(1, 6));
        advance(1'b1, 1'b1, 0, 1'b0);
        fetch_window(1, 1, 0, -1, -1, -1, BEATS);
        ready_handshake($urandom_range(1, 6));
    endtask

    task automatic test_frame_end;
        advance(1'b0, 1'b0, 1, 1'b0);
        do_start(16'h0100, 1'b0);
        fetch_window(0, 0, 1, -1, -1, -1, 30);
    endtask

    task automatic test_reset_mid_fetch;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (mem_rd_en !== 1'b0 || busy !== 1'b0 || me_start !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got rd=%b busy=%b me=%b expected 0 0 0", mem_rd_en, busy, me_start);
        end
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        step;
        vectors++;
        if (mem_rd_en !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL no_resume: got rd=%b busy=%b expected 0 0", mem_rd_en, busy);
        end
        run_frame(16'h0100, 0, 0, 0);
    endtask

    task automatic test_errors;
        run_frame(16'($urandom), 0, 1, 0);
        run_frame(16'($urandom), 1, 0, 1);
        do_start(16'($urandom), 1'b0);
    endtask

    task automatic test_back_to_back;
        for (int f = 0; f < 2; f++) run_frame(16'($urandom), 0, 0, 0);
    endtask

    initial begin
        test_reset;
        test_fetch_order;
        test_ready_handshake;
        test_mb_stepping;
        test_frame_end;
        test_reset_mid_fetch;
        test_back_to_back;
        test_errors;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
